// File: rtl/ex_mul_div_sequencer.sv
// Iterative 32-step shift-add multiply / restoring divide beside the Ex-stage ALU.
// Owns HI/LO and requests pipeline stalls while an operation is in flight.
module ex_mul_div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  operation,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        readRequest,
  output logic        busy,
  output logic        stallRequest,
  output logic        done,
  output logic        divideByZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [4:0]  counter;
  logic [64:0] acc;          // multiply: {P[32:0], multiplier}; divide: {R[32:0], Q}
  logic [31:0] operandM;     // multiplicand magnitude or divisor magnitude
  logic [31:0] rawA;
  logic        isDivide;
  logic        negLow;
  logic        negHigh;
  logic        zeroDivisor;

  logic        isSigned;
  logic        signA;
  logic        signB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [32:0] mulSum;
  logic [64:0] mulNext;
  logic [64:0] divShift;
  logic [32:0] trial;
  logic [64:0] divNext;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] hiResult;
  logic [31:0] loResult;

  assign stallRequest = busy && (start || readRequest);

  always_comb begin
    isSigned = ~operation[0];
    signA    = isSigned & operandA[31];
    signB    = isSigned & operandB[31];
    magA     = signA ? (~operandA + 32'd1) : operandA;
    magB     = signB ? (~operandB + 32'd1) : operandB;

    // Carry out of the 33-bit add is kept before the right shift.
    mulSum   = acc[64:32] + (acc[0] ? {1'b0, operandM} : 33'd0);
    mulNext  = {1'b0, mulSum, acc[31:1]};

    divShift = {acc[63:0], 1'b0};
    trial    = divShift[64:32] - {1'b0, operandM};
    divNext  = trial[32] ? divShift : {trial, divShift[31:1], 1'b1};

    product   = negLow  ? (~acc[63:0]  + 64'd1) : acc[63:0];
    quotient  = negLow  ? (~acc[31:0]  + 32'd1) : acc[31:0];
    remainder = negHigh ? (~acc[63:32] + 32'd1) : acc[63:32];

    if (zeroDivisor) begin
      hiResult = rawA;
      loResult = 32'hFFFF_FFFF;
    end else if (isDivide) begin
      hiResult = remainder;
      loResult = quotient;
    end else begin
      hiResult = product[63:32];
      loResult = product[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counter      <= 5'd0;
      acc          <= 65'd0;
      operandM     <= 32'd0;
      rawA         <= 32'd0;
      isDivide     <= 1'b0;
      negLow       <= 1'b0;
      negHigh      <= 1'b0;
      zeroDivisor  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      divideByZero <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
    end else begin
      done         <= 1'b0;
      divideByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (operation)
              3'b100: hi <= operandA;
              3'b101: lo <= operandA;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                isDivide    <= operation[1];
                rawA        <= operandA;
                zeroDivisor <= operation[1] && (operandB == 32'd0);
                negLow      <= signA ^ signB;
                negHigh     <= signA;
                operandM    <= operation[1] ? magB : magA;
                acc         <= {33'd0, operation[1] ? magA : magB};
                counter     <= 5'd0;
                busy        <= 1'b1;
                state       <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc     <= isDivide ? divNext : mulNext;
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            state        <= FINISH;
            done         <= 1'b1;
            divideByZero <= zeroDivisor;
          end
        end
        FINISH: begin
          hi    <= hiResult;
          lo    <= loResult;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
